// File: rtl/lfsr_job_scheduler.sv
// lfsr_job_scheduler
// Round-robin scheduler that shares one configurable 8-bit LFSR engine
// among NREQ requesters. One job is in flight at a time. The result is
// returned with the id of the requester that submitted it.
`timescale 1ns/1ps
module lfsr_job_scheduler #(
   parameter  int NREQ  = 4,
   parameter  int CNT_W = 8,
   localparam int ID_W  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*8-1:0]     req_seed,
   input  logic [NREQ*8-1:0]     req_tap,
   input  logic [NREQ*CNT_W-1:0] req_steps,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [7:0]            rsp_data,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;

   logic [7:0]       lfsr_reg;
   logic [7:0]       tap_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [ID_W-1:0]  id_reg;
   logic [ID_W-1:0]  ptr_reg;

   logic [7:0]       seed_arr  [NREQ];
   logic [7:0]       tap_arr   [NREQ];
   logic [CNT_W-1:0] steps_arr [NREQ];

   logic             grant_found;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_en;
   logic [ID_W:0]    cand;
   logic             feedback;

   // Unpack the per-requester job fields and build the one-hot ready vector.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign seed_arr[gi]  = req_seed[8*gi +: 8];
         assign tap_arr[gi]   = req_tap[8*gi +: 8];
         assign steps_arr[gi] = req_steps[CNT_W*gi +: CNT_W];
         assign req_ready[gi] = grant_en && (grant_idx == ID_W'(gi));
      end
   endgenerate

   // Next bit entering the shift register: parity of the tapped bits.
   assign feedback = ^(lfsr_reg & tap_reg);

   // Winner search: first valid requester after the last winner, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NREQ)) begin
            cand = cand - (ID_W+1)'(NREQ);
         end
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state logic; zero-step jobs skip RUN and complete at accept.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (grant_en) begin
               state_next = (steps_arr[grant_idx] == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_reg == CNT_W'(1)) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (rsp_ready) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // FSM outputs; grants are only offered in IDLE and never while in reset.
   always_comb begin
      grant_en  = (state_reg == S_IDLE) && grant_found && !reset;
      rsp_valid = (state_reg == S_DONE);
      busy      = (state_reg != S_IDLE);
   end

   // Job datapath: latch the winner's job at accept, step the LFSR in RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_reg <= '0;
         tap_reg  <= '0;
         cnt_reg  <= '0;
         id_reg   <= '0;
         ptr_reg  <= ID_W'(NREQ-1);
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (grant_en) begin
                  lfsr_reg <= seed_arr[grant_idx];
                  tap_reg  <= tap_arr[grant_idx];
                  cnt_reg  <= steps_arr[grant_idx];
                  id_reg   <= grant_idx;
                  ptr_reg  <= grant_idx;
               end
            end
            S_RUN: begin
               lfsr_reg <= {lfsr_reg[6:0], feedback};
               cnt_reg  <= cnt_reg - CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign rsp_data = lfsr_reg;
   assign rsp_id   = id_reg;

endmodule
